// File: rtl/riscv_aes_reg_bank_if.sv
// Bus between the RISC-V decode stage, the AES engine and the AES operand/key register bank.
// master = decode/engine side, slave = register bank.
interface riscv_aes_reg_bank_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int STATE_WORDS = 4,
    parameter int KEY_WORDS   = 8,
    parameter int ADDR_WIDTH  = 3
);
    logic                              cmd_en_i;
    logic [1:0]                        sel_i;
    logic [ADDR_WIDTH-1:0]             waddr_i;
    logic [DATA_WIDTH-1:0]             wdata_i;
    logic                              wen_i;
    logic                              start_i;
    logic                              done_ack_i;
    logic                              res_valid_i;
    logic [STATE_WORDS*DATA_WIDTH-1:0] res_data_i;
    logic [STATE_WORDS*DATA_WIDTH-1:0] state_o;
    logic [KEY_WORDS*DATA_WIDTH-1:0]   key_o;
    logic [1:0]                        key_len_o;
    logic [DATA_WIDTH-1:0]             wb_addr_o;
    logic                              aes_start_o;
    logic                              busy_o;
    logic                              done_o;
    logic                              key_valid_o;
    logic                              err_o;

    modport master (
        output cmd_en_i, sel_i, waddr_i, wdata_i, wen_i, start_i, done_ack_i,
               res_valid_i, res_data_i,
        input  state_o, key_o, key_len_o, wb_addr_o, aes_start_o, busy_o,
               done_o, key_valid_o, err_o
    );

    modport slave (
        input  cmd_en_i, sel_i, waddr_i, wdata_i, wen_i, start_i, done_ack_i,
               res_valid_i, res_data_i,
        output state_o, key_o, key_len_o, wb_addr_o, aes_start_o, busy_o,
               done_o, key_valid_o, err_o
    );
endinterface

// File: rtl/riscv_aes_reg_bank.sv
// AES operand/key register bank with start/busy/done handshake to the AES engine.
// Optional AES_KEY_ZEROIZE_EN: key and written-word mask are wiped when the engine result lands.
module riscv_aes_reg_bank #(
    parameter int DATA_WIDTH  = 32,
    parameter int STATE_WORDS = 4,
    parameter int KEY_WORDS   = 8,
    parameter int ADDR_WIDTH  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 test_en_i,
    riscv_aes_reg_bank_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, START, BUSY, DONE} fsm_t;

    localparam logic [ADDR_WIDTH:0] ST_LIM  = STATE_WORDS[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] KEY_LIM = KEY_WORDS[ADDR_WIDTH:0];

    fsm_t                              fsm_q, fsm_d;
    logic [STATE_WORDS*DATA_WIDTH-1:0] st_q;
    logic [KEY_WORDS*DATA_WIDTH-1:0]   key_q;
    logic [KEY_WORDS-1:0]              mask_q;
    logic [1:0]                        key_len_q;
    logic [DATA_WIDTH-1:0]             wb_addr_q;
    logic                              err_q;

    logic [ADDR_WIDTH:0] waddr_x;
    logic wr, engine_busy, st_ok, key_ok, len_illegal, err_cmd;
    logic st_we, key_we, wb_we, len_we, err_clr, wr_err;
    logic start_req, start_ok, start_err, capture, zeroize, key_valid;
    int   req_n;

    // Key words needed for 128/192/256-bit keys at this word width.
    function automatic int req_words(input logic [1:0] len);
        int bits;
        bits = 128 + 64 * int'(len);
        return (bits + DATA_WIDTH - 1) / DATA_WIDTH;
    endfunction

    assign waddr_x     = {1'b0, bus.waddr_i};
    assign wr          = bus.cmd_en_i & bus.wen_i;
    assign engine_busy = (fsm_q == START) || (fsm_q == BUSY);
    assign st_ok       = waddr_x < ST_LIM;
    assign key_ok      = waddr_x < KEY_LIM;
    assign err_cmd     = bus.wdata_i[DATA_WIDTH-1];
    assign len_illegal = (bus.wdata_i[1:0] == 2'd3) && !err_cmd;

    assign st_we   = wr && (bus.sel_i == 2'd0) && !engine_busy && st_ok;
    assign key_we  = wr && (bus.sel_i == 2'd1) && !engine_busy && key_ok;
    assign wb_we   = wr && (bus.sel_i == 2'd2);
    assign len_we  = wr && (bus.sel_i == 2'd3) && !engine_busy && !err_cmd && !len_illegal;
    assign err_clr = wr && (bus.sel_i == 2'd3) && !engine_busy && err_cmd;
    assign wr_err  = wr && (((bus.sel_i != 2'd2) && engine_busy) ||
                            ((bus.sel_i == 2'd0) && !engine_busy && !st_ok) ||
                            ((bus.sel_i == 2'd1) && !engine_busy && !key_ok) ||
                            ((bus.sel_i == 2'd3) && !engine_busy && len_illegal));

    // Start is judged on the mask as it stood before any same-cycle key write.
    assign start_req = bus.cmd_en_i & bus.start_i;
    assign start_ok  = start_req && key_valid && ((fsm_q == IDLE) || (fsm_q == DONE));
    assign start_err = start_req && !start_ok;
    assign capture   = (fsm_q == BUSY) && bus.res_valid_i;

`ifdef AES_KEY_ZEROIZE_EN
    assign zeroize = capture;
`else
    assign zeroize = 1'b0;
`endif

    always_comb begin
        req_n     = req_words(key_len_q);
        key_valid = (req_n <= KEY_WORDS);
        for (int i = 0; i < KEY_WORDS; i++) begin
            if ((i < req_n) && !mask_q[i]) key_valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (start_ok) fsm_d = START;
            START:   fsm_d = BUSY;
            BUSY:    if (bus.res_valid_i) fsm_d = DONE;
            DONE: begin
                if (start_ok)            fsm_d = START;
                else if (bus.done_ack_i) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_comb begin
        bus.aes_start_o = (fsm_q == START);
        bus.busy_o      = engine_busy;
        bus.done_o      = (fsm_q == DONE);
    end

    // Test mode overrides both CPU writes and engine capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= '0;
        end else if (test_en_i) begin
            st_q <= '1;
        end else if (capture) begin
            st_q <= bus.res_data_i;
        end else begin
            for (int i = 0; i < STATE_WORDS; i++) begin
                if (st_we && (int'(waddr_x) == i)) st_q[i*DATA_WIDTH +: DATA_WIDTH] <= bus.wdata_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q  <= '0;
            mask_q <= '0;
        end else if (zeroize) begin
            key_q  <= '0;
            mask_q <= '0;
        end else if (len_we) begin
            mask_q <= '0;
        end else begin
            for (int i = 0; i < KEY_WORDS; i++) begin
                if (key_we && (int'(waddr_x) == i)) begin
                    key_q[i*DATA_WIDTH +: DATA_WIDTH] <= bus.wdata_i;
                    mask_q[i]                         <= 1'b1;
                end
            end
        end
    end

    // A new error in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_len_q <= 2'd0;
            wb_addr_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (len_we) key_len_q <= bus.wdata_i[1:0];
            if (wb_we)  wb_addr_q <= bus.wdata_i;
            if (wr_err || start_err) err_q <= 1'b1;
            else if (err_clr)        err_q <= 1'b0;
        end
    end

    assign bus.state_o     = st_q;
    assign bus.key_o       = key_q;
    assign bus.key_len_o   = key_len_q;
    assign bus.wb_addr_o   = wb_addr_q;
    assign bus.key_valid_o = key_valid;
    assign bus.err_o       = err_q;

endmodule

// File: tb/tb_riscv_aes_reg_bank.sv
// Directed bench for riscv_aes_reg_bank; engine results are scoreboarded through a queue.
module tb_riscv_aes_reg_bank;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic test_en = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [127:0] exp_q[$];
    logic [255:0] exp_key = '0;
    logic [127:0] exp_state = '0;

    riscv_aes_reg_bank_if #(.DATA_WIDTH(32), .STATE_WORDS(4), .KEY_WORDS(8), .ADDR_WIDTH(3)) bus ();

    riscv_aes_reg_bank #(.DATA_WIDTH(32), .STATE_WORDS(4), .KEY_WORDS(8), .ADDR_WIDTH(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .test_en_i (test_en),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_inputs();
        bus.cmd_en_i    = 1'b0;
        bus.sel_i       = 2'd0;
        bus.waddr_i     = 3'd0;
        bus.wdata_i     = 32'h0;
        bus.wen_i       = 1'b0;
        bus.start_i     = 1'b0;
        bus.done_ack_i  = 1'b0;
        bus.res_valid_i = 1'b0;
        bus.res_data_i  = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input int addr, input logic [31:0] data);
        bus.cmd_en_i = 1'b1;
        bus.wen_i    = 1'b1;
        bus.sel_i    = sel;
        bus.waddr_i  = addr[2:0];
        bus.wdata_i  = data;
        cyc();
        clr_inputs();
    endtask

    task automatic wr_key(input int i, input logic [31:0] d);
        wr(2'd1, i, d);
        exp_key[i*32 +: 32] = d;
    endtask

    task automatic start();
        bus.cmd_en_i = 1'b1;
        bus.start_i  = 1'b1;
        cyc();
        clr_inputs();
    endtask

    task automatic engine_result(input logic [127:0] data);
        bus.res_valid_i = 1'b1;
        bus.res_data_i  = data;
        exp_q.push_back(test_en ? {128{1'b1}} : data);
        cyc();
        clr_inputs();
    endtask

    task automatic wait_done_and_score(input string tag);
        int n = 0;
        logic [127:0] exp;
        while (!bus.done_o && n < 20) begin
            cyc();
            n++;
        end
        chk({tag, "_done"}, bus.done_o, 1);
        chk({tag, "_qlen"}, exp_q.size(), 1);
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            exp_state = exp;
            chk({tag, "_state"}, bus.state_o, exp);
        end
    endtask

    initial begin
        clr_inputs();
        cyc();
        cyc();
        chk("rst_state",  bus.state_o, 0);
        chk("rst_key",    bus.key_o, 0);
        chk("rst_keylen", bus.key_len_o, 0);
        chk("rst_wb",     bus.wb_addr_o, 0);
        chk("rst_flags",  {bus.aes_start_o, bus.busy_o, bus.done_o, bus.key_valid_o, bus.err_o}, 0);
        rst_n = 1'b1;
        cyc();

        // 128-bit key, load state, run one operation
        wr(2'd3, 0, 32'd0);
        for (int i = 0; i < 4; i++) wr_key(i, 32'h0F0E_0D00 + i);
        chk("kv128", bus.key_valid_o, 1);
        chk("key128", bus.key_o, exp_key);
        wr(2'd0, 0, 32'h0011_2233);
        wr(2'd0, 1, 32'h4455_6677);
        wr(2'd0, 2, 32'h8899_AABB);
        wr(2'd0, 3, 32'hCCDD_EEFF);
        exp_state = 128'hCCDD_EEFF_8899_AABB_4455_6677_0011_2233;
        chk("state_wr", bus.state_o, exp_state);
        start();
        chk("start_pulse", {bus.aes_start_o, bus.busy_o}, 2'b11);
        cyc();
        chk("pulse_end", {bus.aes_start_o, bus.busy_o}, 2'b01);
        engine_result({4{32'hDEAD_BEEF}});
        wait_done_and_score("op1");
        chk("op1_busy", bus.busy_o, 0);
`ifdef AES_KEY_ZEROIZE_EN
        exp_key = '0;
        chk("op1_key", bus.key_o, exp_key);
        chk("op1_kv", bus.key_valid_o, 0);
`else
        chk("op1_key", bus.key_o, exp_key);
        chk("op1_kv", bus.key_valid_o, 1);
`endif
        bus.done_ack_i = 1'b1;
        cyc();
        clr_inputs();
        chk("ack_idle", {bus.done_o, bus.busy_o}, 0);

        // 256-bit key, incomplete then complete
        wr(2'd3, 0, 32'd2);
        chk("keylen2", bus.key_len_o, 2);
        for (int i = 0; i < 6; i++) wr_key(i, 32'hA5A5_0000 + i);
        chk("kv_6of8", bus.key_valid_o, 0);
        start();
        chk("rej_start", {bus.aes_start_o, bus.busy_o, bus.err_o}, 3'b001);
        wr_key(6, 32'hA5A5_0006);
        wr_key(7, 32'hA5A5_0007);
        chk("kv256", bus.key_valid_o, 1);
        wr(2'd3, 0, 32'h8000_0000);
        chk("err_clr", bus.err_o, 0);
        chk("clr_keeps_len", bus.key_len_o, 2);
        start();
        chk("start256", bus.aes_start_o, 1);
        cyc();

        // Writes while the engine runs
        wr(2'd0, 0, 32'h5);
        chk("busy_st_drop", bus.state_o, exp_state);
        chk("busy_st_err", bus.err_o, 1);
        wr(2'd2, 0, 32'h1000);
        chk("busy_wb", bus.wb_addr_o, 32'h1000);

        // Capture under test mode
        test_en = 1'b1;
        engine_result(128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
        test_en = 1'b0;
        wait_done_and_score("op2");
`ifdef AES_KEY_ZEROIZE_EN
        exp_key = '0;
        chk("op2_kv", bus.key_valid_o, 0);
`else
        chk("op2_kv", bus.key_valid_o, 1);
`endif
        chk("op2_key", bus.key_o, exp_key);

        // Illegal accesses while DONE
        wr(2'd3, 0, 32'h8000_0000);
        chk("err_clr2", bus.err_o, 0);
        wr(2'd3, 0, 32'd3);
        chk("len3_err", {bus.err_o, bus.key_len_o}, 3'b110);
        wr(2'd3, 0, 32'h8000_0000);
        wr(2'd0, 4, 32'h1234_5678);
        chk("oob_err", bus.err_o, 1);
        chk("oob_state", bus.state_o, exp_state);
        bus.done_ack_i = 1'b1;
        cyc();
        clr_inputs();
        chk("ack2_idle", bus.done_o, 0);

        // Same-cycle write of the last key word and start
        wr(2'd3, 0, 32'h8000_0000);
        wr(2'd3, 0, 32'd0);
        for (int i = 0; i < 3; i++) wr_key(i, 32'h7700_0000 + i);
        bus.cmd_en_i = 1'b1;
        bus.wen_i    = 1'b1;
        bus.sel_i    = 2'd1;
        bus.waddr_i  = 3'd3;
        bus.wdata_i  = 32'h7700_0003;
        bus.start_i  = 1'b1;
        cyc();
        clr_inputs();
        chk("same_cyc", {bus.aes_start_o, bus.key_valid_o, bus.err_o}, 3'b011);
        start();
        chk("start3", bus.aes_start_o, 1);
        cyc();
        chk("busy3", bus.busy_o, 1);

        // Asynchronous reset mid-operation
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_flags", {bus.aes_start_o, bus.busy_o, bus.done_o, bus.key_valid_o, bus.err_o}, 0);
        chk("arst_state", bus.state_o, 0);
        chk("arst_key", bus.key_o, 0);
        chk("arst_wb", {bus.wb_addr_o, bus.key_len_o}, 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
